// File: rtl/regfile_rat_pkg.sv
// Register alias table types and constants, sized to match the reorder buffer.
package regfile_rat_pkg;
  localparam int ROB_ENTRIES = 8;
  localparam int ROB_TAG_W   = $clog2(ROB_ENTRIES);
  localparam int NUM_REGS    = 32;

  typedef struct packed {
    logic                 busy;
    logic [ROB_TAG_W-1:0] tag;
  } rat_entry_t;

  // A retiring entry owns rd only if it is still the newest recorded producer.
  function automatic logic tag_match(input rat_entry_t e, input logic [ROB_TAG_W-1:0] t);
    return e.busy && (e.tag == t);
  endfunction
endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I scalar types used across the core.
package rv32i_types;
  typedef logic [4:0]  rv32i_reg;
  typedef logic [31:0] rv32i_word;
endpackage

// File: rtl/regfile_read_port.sv
// One decoder source port: x0 masking, RAT lookup and (with COMMIT_BYPASS_EN) commit forwarding.
// Purely combinational.
module regfile_read_port
  import rv32i_types::*;
  import regfile_rat_pkg::*;
(
  input  rv32i_reg             rs_i,
  input  rat_entry_t           rat_i,
  input  rv32i_word            reg_val_i,
`ifdef COMMIT_BYPASS_EN
  input  logic                 commit_valid_i,
  input  rv32i_reg             commit_rd_i,
  input  logic [ROB_TAG_W-1:0] commit_tag_i,
  input  rv32i_word            commit_val_i,
`endif
  output rv32i_word            val_o,
  output logic                 busy_o,
  output logic [ROB_TAG_W-1:0] tag_o
);

  always_comb begin
    val_o  = reg_val_i;
    busy_o = rat_i.busy;
    tag_o  = rat_i.tag;
`ifdef COMMIT_BYPASS_EN
    // A stale commit still forwards its value; only the owning producer clears busy.
    if (commit_valid_i && (rs_i == commit_rd_i)) begin
      val_o = commit_val_i;
      if (tag_match(rat_i, commit_tag_i)) begin
        busy_o = 1'b0;
      end
    end
`endif
    if (rs_i == '0) begin
      val_o  = '0;
      busy_o = 1'b0;
      tag_o  = '0;
    end
  end

endmodule

// File: rtl/regfile_rat.sv
// Architectural register file + register alias table; commit side of the ROB.
// Optional macro COMMIT_BYPASS_EN forwards a same-cycle commit into both read ports.
module regfile_rat
  import rv32i_types::*;
  import regfile_rat_pkg::*;
#(
  parameter int ROB_ENTRIES = regfile_rat_pkg::ROB_ENTRIES,
  parameter int NUM_REGS    = regfile_rat_pkg::NUM_REGS,
  localparam int TAG_W      = $clog2(ROB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid_i,
  input  logic [4:0]       alloc_rd_i,
  input  logic [TAG_W-1:0] alloc_tag_i,
  input  logic             commit_valid_i,
  input  logic [4:0]       commit_rd_i,
  input  logic [TAG_W-1:0] commit_tag_i,
  input  logic [31:0]      commit_val_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  output logic [31:0]      rs1_val_o,
  output logic [31:0]      rs2_val_o,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic [TAG_W-1:0] rs1_tag_o,
  output logic [TAG_W-1:0] rs2_tag_o
);

  rv32i_word  regs_q [NUM_REGS];
  rv32i_word  regs_d [NUM_REGS];
  rat_entry_t rat_q  [NUM_REGS];
  rat_entry_t rat_d  [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    rat_d  = rat_q;
    if (commit_valid_i && (commit_rd_i != '0)) begin
      regs_d[commit_rd_i] = commit_val_i;
      if (tag_match(rat_q[commit_rd_i], commit_tag_i)) begin
        rat_d[commit_rd_i].busy = 1'b0;
      end
    end
    // Alloc is applied after commit so the newest producer wins on a shared rd.
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rat_d[i] = '0;
      end
    end else if (alloc_valid_i && (alloc_rd_i != '0)) begin
      rat_d[alloc_rd_i].busy = 1'b1;
      rat_d[alloc_rd_i].tag  = alloc_tag_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
        rat_q[i]  <= '0;
      end
    end else begin
      regs_q <= regs_d;
      rat_q  <= rat_d;
    end
  end

`ifdef COMMIT_BYPASS_EN
  logic commit_fwd_vld;
  assign commit_fwd_vld = commit_valid_i & ~rst;
`endif

  regfile_read_port u_rd1 (
    .rs_i           (rs1_i),
    .rat_i          (rat_q[rs1_i]),
    .reg_val_i      (regs_q[rs1_i]),
`ifdef COMMIT_BYPASS_EN
    .commit_valid_i (commit_fwd_vld),
    .commit_rd_i    (commit_rd_i),
    .commit_tag_i   (commit_tag_i),
    .commit_val_i   (commit_val_i),
`endif
    .val_o          (rs1_val_o),
    .busy_o         (rs1_busy_o),
    .tag_o          (rs1_tag_o)
  );

  regfile_read_port u_rd2 (
    .rs_i           (rs2_i),
    .rat_i          (rat_q[rs2_i]),
    .reg_val_i      (regs_q[rs2_i]),
`ifdef COMMIT_BYPASS_EN
    .commit_valid_i (commit_fwd_vld),
    .commit_rd_i    (commit_rd_i),
    .commit_tag_i   (commit_tag_i),
    .commit_val_i   (commit_val_i),
`endif
    .val_o          (rs2_val_o),
    .busy_o         (rs2_busy_o),
    .tag_o          (rs2_tag_o)
  );

endmodule
